// File: rtl/uart_tx_feeder.sv
// Transmit holding FIFO and character launcher that feeds uart_transmitter one byte at a time.
// Optional build macro UART_TX_FIFO_THRESH_EN adds the TRIG input and the registered TXTRIG output.
module uart_tx_feeder #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          FIFOE,
    input  logic          CLEAR,
    input  logic          WE,
    input  logic [7:0]    WDATA,
    input  logic          TXFINISHED,
`ifdef UART_TX_FIFO_THRESH_EN
    input  logic [1:0]    TRIG,
    output logic          TXTRIG,
`endif
    output logic          TXSTART,
    output logic [7:0]    DOUT,
    output logic          EMPTY,
    output logic          FULL,
    output logic [CW-1:0] COUNT,
    output logic          THRE,
    output logic          OVFL
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] eff_depth;
    logic [7:0]    dout_q;
    logic          ovfl_q;
    logic          push;
    logic          pop;

    // Character mode behaves as a one-entry FIFO; >= keeps FULL asserted if the
    // mode is switched without the required flush.
    assign eff_depth = FIFOE ? CW'(DEPTH) : CW'(1);
    assign EMPTY     = (count == '0);
    assign FULL      = (count >= eff_depth);

    // A flush suppresses both ends of the FIFO, so nothing is loaded that cycle.
    assign push = WE && !FULL && !CLEAR;
    assign pop  = !EMPTY && !CLEAR && ((state == IDLE) || TXFINISHED);

    assign TXSTART = (state == ARMED);
    assign DOUT    = dout_q;
    assign COUNT   = count;
    assign OVFL    = ovfl_q;
    assign THRE    = EMPTY && (state == IDLE);

    // NOTE: storage carries no reset; entries are only observable after a push writes them.
    always_ff @(posedge CLK) begin
        if (!RST && push) begin
            mem[wr_ptr] <= WDATA;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovfl_q <= 1'b0;
        end else if (CLEAR) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovfl_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (WE && FULL) begin
                ovfl_q <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Launcher: DOUT only moves on the initial load or on a TXFINISHED pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            dout_q <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        dout_q <= mem[rd_ptr];
                        state  <= ARMED;
                    end
                end
                ARMED: begin
                    if (TXFINISHED) begin
                        if (pop) begin
                            dout_q <= mem[rd_ptr];
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_TX_FIFO_THRESH_EN
    int thresh;

    always_comb begin
        thresh = 0;
        case (TRIG)
            2'd0:    thresh = 0;
            2'd1:    thresh = 2;
            2'd2:    thresh = 4;
            default: thresh = 8;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            TXTRIG <= 1'b0;
        end else begin
            TXTRIG <= FIFOE && (int'(count) <= thresh);
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: accepted bytes are queued at write time and
// compared against DOUT whenever the launcher loads a character.
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic          fifoe;
    logic          clear;
    logic          we;
    logic [7:0]    wdata;
    logic          txfinished;
    logic          txstart;
    logic [7:0]    dout;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          thre;
    logic          ovfl;
`ifdef UART_TX_FIFO_THRESH_EN
    logic [1:0]    trig;
    logic          txtrig;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q [$];

    uart_tx_feeder #(.DEPTH(DEPTH), .CW(CW)) dut (
        .CLK        (clk),
        .RST        (rst),
        .FIFOE      (fifoe),
        .CLEAR      (clear),
        .WE         (we),
        .WDATA      (wdata),
        .TXFINISHED (txfinished),
`ifdef UART_TX_FIFO_THRESH_EN
        .TRIG       (trig),
        .TXTRIG     (txtrig),
`endif
        .TXSTART    (txstart),
        .DOUT       (dout),
        .EMPTY      (empty),
        .FULL       (full),
        .COUNT      (count),
        .THRE       (thre),
        .OVFL       (ovfl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic get_exp(output logic [7:0] e);
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_underflow got=empty want=queued_byte");
            e = 8'hxx;
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    task automatic pulse_finished();
        txfinished = 1'b1;
        tick();
        txfinished = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (txstart !== 1'b0) begin bad++; $display("FAIL reset_txstart got=%b want=0", txstart); end
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h want=00", dout); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
        total++; if (thre !== 1'b1) begin bad++; $display("FAIL reset_thre got=%b want=1", thre); end
        total++; if (ovfl !== 1'b0) begin bad++; $display("FAIL reset_ovfl got=%b want=0", ovfl); end
    endtask

    task automatic test_single();
        logic [7:0] e;
        fifoe = 1'b1;
        we = 1'b1; wdata = 8'hA5; exp_q.push_back(8'hA5);
        tick();
        we = 1'b0;
        total++; if (count !== 5'd1) begin bad++; $display("FAIL single_count1 got=%0d want=1", count); end
        total++; if (txstart !== 1'b0) begin bad++; $display("FAIL single_txstart_early got=%b want=0", txstart); end
        tick();
        get_exp(e);
        total++; if (txstart !== 1'b1) begin bad++; $display("FAIL single_txstart got=%b want=1", txstart); end
        total++; if (dout !== e) begin bad++; $display("FAIL single_dout got=%h want=%h", dout, e); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL single_count0 got=%0d want=0", count); end
        total++; if (thre !== 1'b0) begin bad++; $display("FAIL single_thre_armed got=%b want=0", thre); end
        pulse_finished();
        total++; if (txstart !== 1'b0) begin bad++; $display("FAIL single_txstart_drop got=%b want=0", txstart); end
        total++; if (thre !== 1'b1) begin bad++; $display("FAIL single_thre_idle got=%b want=1", thre); end
    endtask

    task automatic test_burst();
        logic [7:0] e;
        for (int i = 0; i < 17; i++) begin
            we = 1'b1; wdata = 8'(i); exp_q.push_back(8'(i));
            tick();
        end
        we = 1'b0;
        get_exp(e);
        total++; if (dout !== e) begin bad++; $display("FAIL burst_dout got=%h want=%h", dout, e); end
        total++; if (txstart !== 1'b1) begin bad++; $display("FAIL burst_txstart got=%b want=1", txstart); end
        total++; if (count !== 5'd16) begin bad++; $display("FAIL burst_count got=%0d want=16", count); end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL burst_full got=%b want=1", full); end
        total++; if (ovfl !== 1'b0) begin bad++; $display("FAIL burst_ovfl_clean got=%b want=0", ovfl); end
        we = 1'b1; wdata = 8'hFF;
        tick();
        we = 1'b0;
        total++; if (ovfl !== 1'b1) begin bad++; $display("FAIL burst_ovfl_set got=%b want=1", ovfl); end
        total++; if (count !== 5'd16) begin bad++; $display("FAIL burst_count_drop got=%0d want=16", count); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        for (int k = 0; k < 16; k++) begin
            pulse_finished();
            get_exp(e);
            total++; if (dout !== e) begin bad++; $display("FAIL b2b_dout[%0d] got=%h want=%h", k, dout, e); end
            total++; if (txstart !== 1'b1) begin bad++; $display("FAIL b2b_txstart[%0d] got=%b want=1", k, txstart); end
            for (int j = 0; j < 9; j++) tick();
            total++; if (txstart !== 1'b1) begin bad++; $display("FAIL b2b_txstart_hold[%0d] got=%b want=1", k, txstart); end
        end
        pulse_finished();
        total++; if (txstart !== 1'b0) begin bad++; $display("FAIL b2b_final_txstart got=%b want=0", txstart); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_final_empty got=%b want=1", empty); end
    endtask

    task automatic test_clear();
        logic [7:0] e;
        for (int i = 0; i < 6; i++) begin
            we = 1'b1; wdata = 8'h40 + 8'(i); exp_q.push_back(8'h40 + 8'(i));
            tick();
        end
        we = 1'b0;
        get_exp(e);
        total++; if (dout !== e) begin bad++; $display("FAIL clear_pre_dout got=%h want=%h", dout, e); end
        total++; if (count !== 5'd5) begin bad++; $display("FAIL clear_pre_count got=%0d want=5", count); end
        total++; if (ovfl !== 1'b1) begin bad++; $display("FAIL clear_pre_ovfl got=%b want=1", ovfl); end
        clear = 1'b1; we = 1'b1; wdata = 8'h99;
        tick();
        clear = 1'b0; we = 1'b0;
        exp_q.delete();
        total++; if (count !== 5'd0) begin bad++; $display("FAIL clear_count got=%0d want=0", count); end
        total++; if (ovfl !== 1'b0) begin bad++; $display("FAIL clear_ovfl got=%b want=0", ovfl); end
        total++; if (txstart !== 1'b1) begin bad++; $display("FAIL clear_txstart got=%b want=1", txstart); end
        total++; if (dout !== 8'h40) begin bad++; $display("FAIL clear_dout got=%h want=40", dout); end
        tick();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL clear_we_dropped got=%b want=1", empty); end
        pulse_finished();
        total++; if (txstart !== 1'b0) begin bad++; $display("FAIL clear_idle got=%b want=0", txstart); end
    endtask

    task automatic test_full_pop();
        logic [7:0] e;
        for (int i = 0; i < 17; i++) begin
            we = 1'b1; wdata = 8'h50 + 8'(i); exp_q.push_back(8'h50 + 8'(i));
            tick();
        end
        we = 1'b0;
        get_exp(e);
        total++; if (dout !== e) begin bad++; $display("FAIL fullpop_pre_dout got=%h want=%h", dout, e); end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fullpop_pre_full got=%b want=1", full); end
        we = 1'b1; wdata = 8'hEE; txfinished = 1'b1;
        tick();
        we = 1'b0; txfinished = 1'b0;
        get_exp(e);
        total++; if (dout !== e) begin bad++; $display("FAIL fullpop_dout got=%h want=%h", dout, e); end
        total++; if (count !== 5'd15) begin bad++; $display("FAIL fullpop_count got=%0d want=15", count); end
        total++; if (ovfl !== 1'b1) begin bad++; $display("FAIL fullpop_ovfl got=%b want=1", ovfl); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL fullpop_full got=%b want=0", full); end
        for (int k = 0; k < 15; k++) begin
            pulse_finished();
            get_exp(e);
            total++; if (dout !== e) begin bad++; $display("FAIL fullpop_drain[%0d] got=%h want=%h", k, dout, e); end
        end
        pulse_finished();
        total++; if (txstart !== 1'b0) begin bad++; $display("FAIL fullpop_idle got=%b want=0", txstart); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL fullpop_empty got=%b want=1", empty); end
    endtask

    task automatic test_char_mode();
        logic [7:0] e;
        fifoe = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        we = 1'b1; wdata = 8'h11; exp_q.push_back(8'h11);
        tick();
        we = 1'b0;
        tick();
        get_exp(e);
        total++; if (dout !== e) begin bad++; $display("FAIL char_dout1 got=%h want=%h", dout, e); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL char_full0 got=%b want=0", full); end
        we = 1'b1; wdata = 8'h22; exp_q.push_back(8'h22);
        tick();
        total++; if (full !== 1'b1) begin bad++; $display("FAIL char_full1 got=%b want=1", full); end
        total++; if (ovfl !== 1'b0) begin bad++; $display("FAIL char_ovfl0 got=%b want=0", ovfl); end
        wdata = 8'h33;
        tick();
        we = 1'b0;
        total++; if (ovfl !== 1'b1) begin bad++; $display("FAIL char_ovfl1 got=%b want=1", ovfl); end
        total++; if (count !== 5'd1) begin bad++; $display("FAIL char_count got=%0d want=1", count); end
        pulse_finished();
        get_exp(e);
        total++; if (dout !== e) begin bad++; $display("FAIL char_dout2 got=%h want=%h", dout, e); end
        total++; if (txstart !== 1'b1) begin bad++; $display("FAIL char_txstart got=%b want=1", txstart); end
        pulse_finished();
        total++; if (txstart !== 1'b0) begin bad++; $display("FAIL char_idle got=%b want=0", txstart); end
        fifoe = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_rst_armed();
        logic [7:0] e;
        we = 1'b1; wdata = 8'h77; exp_q.push_back(8'h77);
        tick();
        wdata = 8'h88;
        tick();
        we = 1'b0;
        get_exp(e);
        total++; if (dout !== e) begin bad++; $display("FAIL rst_pre_dout got=%h want=%h", dout, e); end
        fifoe = 1'b0; we = 1'b1; wdata = 8'h99;
        tick();
        we = 1'b0;
        total++; if (ovfl !== 1'b1) begin bad++; $display("FAIL rst_pre_ovfl got=%b want=1", ovfl); end
        rst = 1'b1;
        tick();
        rst = 1'b0; fifoe = 1'b1;
        exp_q.delete();
        total++; if (txstart !== 1'b0) begin bad++; $display("FAIL rst_txstart got=%b want=0", txstart); end
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL rst_dout got=%h want=00", dout); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b want=1", empty); end
        total++; if (thre !== 1'b1) begin bad++; $display("FAIL rst_thre got=%b want=1", thre); end
        total++; if (ovfl !== 1'b0) begin bad++; $display("FAIL rst_ovfl got=%b want=0", ovfl); end
    endtask

    initial begin
        rst = 1'b1; fifoe = 1'b1; clear = 1'b0; we = 1'b0; wdata = 8'h00; txfinished = 1'b0;
`ifdef UART_TX_FIFO_THRESH_EN
        trig = 2'd0;
`endif
        test_reset();
        test_single();
        test_burst();
        test_back_to_back();
        test_clear();
        test_full_pop();
        test_char_mode();
        test_rst_armed();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
